// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core definitions: load funct3 encodings and the
//               MEM/WB stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Load width/sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM/WB stage states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational extraction of load data from a 32-bit memory
//               word according to funct3 and the low address bits.
// Ports       : funct3_i [2:0]  load width/sign
//               addr_i   [1:0]  byte offset within the word
//               rdata_i  [31:0] raw memory word
//               data_o   [31:0] aligned, extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        // Halfword selection looks only at addr[1]; a set addr[0] is not trapped
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Reserved encodings (011/110/111) fall through to a full word
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline stage. Non-loads write back one cycle after
//               acceptance; loads stall upstream until the data memory
//               responds, then write back the aligned data.
// Config      : MEM_WB_LOAD_TIMEOUT_EN - when defined, a watchdog abandons a
//               load after LOAD_TIMEOUT wait cycles and pulses load_err_o.
//               When undefined, loads wait indefinitely and load_err_o is 0.
// Ports       : clk_i, rst_ni (async, active-low)
//               ex_*           instruction from EX (accepted only when idle)
//               dmem_rvalid_i, dmem_rdata_i  data-memory response
//               stall_o        upstream hold while a load is outstanding
//               wb_reg_write_o, wb_rd_o, wb_data_o  register-file write port
//               load_err_o     one-cycle load-timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_result_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        load_err_o
);

    if (LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 255) begin : g_load_timeout_range
        $error("LOAD_TIMEOUT must be within 1..255");
    end

    state_e      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic        ld_we_q, ld_we_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] load_data;
    logic        timeout;

    load_align u_load_align (
        .funct3_i (ld_funct3_q),
        .addr_i   (ld_addr_q),
        .rdata_i  (dmem_rdata_i),
        .data_o   (load_data)
    );

`ifdef MEM_WB_LOAD_TIMEOUT_EN
    localparam logic [7:0] c_wdog_last = 8'(LOAD_TIMEOUT - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       load_err_q;

    // The limit is hit on the WAIT cycle that would bring the count to
    // LOAD_TIMEOUT; a response in that same cycle takes priority.
    assign timeout = (state_q == WAIT) && !dmem_rvalid_i && (wdog_q == c_wdog_last);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE) begin
            wdog_d = '0;
        end else if (!dmem_rvalid_i) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q     <= '0;
            load_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            load_err_q <= timeout;
        end
    end

    assign load_err_o = load_err_q;
`else
    assign timeout    = 1'b0;
    assign load_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_addr_d   = ld_addr_q;
        ld_we_d     = ld_we_q;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;

        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (ex_mem_read_i) begin
                        ld_rd_d     = ex_rd_i;
                        ld_funct3_d = ex_funct3_i;
                        ld_addr_d   = ex_result_i[1:0];
                        ld_we_d     = ex_reg_write_i;
                        state_d     = WAIT;
                    end else begin
                        wb_rd_d   = ex_rd_i;
                        wb_data_d = ex_result_i;
                        wb_we_d   = ex_reg_write_i && (ex_rd_i != 5'd0);
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    wb_rd_d   = ld_rd_q;
                    wb_data_d = load_data;
                    wb_we_d   = ld_we_q && (ld_rd_q != 5'd0);
                    state_d   = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_addr_q   <= '0;
            ld_we_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_addr_q   <= ld_addr_d;
            ld_we_q     <= ld_we_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Stall covers the response cycle too, since it is still a WAIT cycle
    assign stall_o        = (state_q == WAIT);
    assign wb_reg_write_o = wb_we_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. A vector table drives
//               ALU ops and loads; expected write-backs go into a queue that
//               a monitor drains whenever the DUT pulses wb_reg_write_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall, wb_we, load_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        is_load;
        logic        rw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] result;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];

    mem_wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ex_valid_i     (ex_valid),
        .ex_reg_write_i (ex_reg_write),
        .ex_mem_read_i  (ex_mem_read),
        .ex_rd_i        (ex_rd),
        .ex_funct3_i    (ex_funct3),
        .ex_result_i    (ex_result),
        .dmem_rvalid_i  (dmem_rvalid),
        .dmem_rdata_i   (dmem_rdata),
        .stall_o        (stall),
        .wb_reg_write_o (wb_we),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .load_err_o     (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic rw, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [31:0] res,
                                input logic [31:0] rdata, input int dly,
                                input logic [31:0] exp_d);
        vec_t v;
        v.is_load = ld; v.rw = rw; v.rd = rd; v.f3 = f3; v.result = res;
        v.rdata = rdata; v.delay = dly; v.exp_data = exp_d;
        return v;
    endfunction

    // Scoreboard drain: every write pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, required no write", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("sb_data", wb_data, e.data);
            end
        end
    end

    task automatic apply(input vec_t v);
        ex_valid     = 1'b1;
        ex_reg_write = v.rw;
        ex_mem_read  = v.is_load;
        ex_rd        = v.rd;
        ex_funct3    = v.f3;
        ex_result    = v.result;
        if (v.rw && v.rd != 5'd0) sb.push_back('{v.rd, v.exp_data});
        tick();
        if (v.is_load) begin
            // Junk instruction offered during WAIT must be ignored
            ex_mem_read  = 1'b0;
            ex_reg_write = 1'b1;
            ex_rd        = 5'd31;
            ex_result    = 32'hBAD0_BAD0;
            for (int i = 0; i < v.delay; i++) begin
                chk("stall_wait", {31'd0, stall}, 32'd1);
                if (i == v.delay - 1) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = v.rdata;
                end
                tick();
            end
            dmem_rvalid = 1'b0;
        end
        ex_valid = 1'b0;
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("wb_we", {31'd0, wb_we}, {31'd0, (v.rw && v.rd != 5'd0)});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        chk("wb_data", wb_data, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(0, 1, 5'd5,  3'b000, 32'h0000_1234, 32'h0,          0, 32'h0000_1234);
        vecs[1]  = mk(1, 1, 5'd7,  F3_LB,  32'h0000_1003, 32'h80FF_0011, 3, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 1, 5'd9,  F3_LHU, 32'h0000_1002, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        vecs[3]  = mk(1, 1, 5'd10, F3_LB,  32'h0000_1000, 32'h80FF_0011, 2, 32'h0000_0011);
        vecs[4]  = mk(1, 1, 5'd11, F3_LB,  32'h0000_1001, 32'h80FF_0011, 1, 32'h0000_0000);
        vecs[5]  = mk(1, 1, 5'd12, F3_LB,  32'h0000_1002, 32'h80FF_0011, 4, 32'hFFFF_FFFF);
        vecs[6]  = mk(1, 1, 5'd13, F3_LBU, 32'h0000_1003, 32'h80FF_0011, 1, 32'h0000_0080);
        vecs[7]  = mk(1, 1, 5'd14, F3_LBU, 32'h0000_1002, 32'h80FF_0011, 2, 32'h0000_00FF);
        vecs[8]  = mk(1, 1, 5'd15, F3_LH,  32'h0000_1000, 32'h80FF_8011, 1, 32'hFFFF_8011);
        vecs[9]  = mk(1, 1, 5'd16, F3_LH,  32'h0000_1001, 32'h80FF_8011, 1, 32'hFFFF_8011);
        vecs[10] = mk(1, 1, 5'd17, F3_LH,  32'h0000_1002, 32'h80FF_0011, 3, 32'hFFFF_80FF);
        vecs[11] = mk(1, 1, 5'd18, F3_LHU, 32'h0000_1003, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        vecs[12] = mk(1, 1, 5'd19, F3_LHU, 32'h0000_1001, 32'hBEEF_1234, 2, 32'h0000_1234);
        vecs[13] = mk(1, 1, 5'd20, F3_LW,  32'h0000_1001, 32'h80FF_0011, 1, 32'h80FF_0011);
        vecs[14] = mk(1, 1, 5'd21, 3'b011, 32'h0000_1002, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        vecs[15] = mk(1, 1, 5'd22, 3'b110, 32'h0000_1000, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
        vecs[16] = mk(1, 1, 5'd23, 3'b111, 32'h0000_1003, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        vecs[17] = mk(0, 0, 5'd31, 3'b000, 32'hDEAD_BEEF, 32'h0,          0, 32'hDEAD_BEEF);

        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = '0;
        ex_funct3    = '0;
        ex_result    = '0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = '0;
        repeat (3) tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) apply(vecs[i]);

        // x0 guard: data/rd update, no write
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b0;
        ex_rd = 5'd0; ex_result = 32'h5555_AAAA;
        tick();
        ex_valid = 1'b0;
        chk("x0_we", {31'd0, wb_we}, 32'd0);
        chk("x0_rd", {27'd0, wb_rd}, 32'd0);
        chk("x0_data", wb_data, 32'h5555_AAAA);

        // Stray responses in IDLE change nothing
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        tick();
        dmem_rvalid = 1'b0;
        chk("stray_stall", {31'd0, stall}, 32'd0);
        chk("stray_we", {31'd0, wb_we}, 32'd0);
        chk("stray_data", wb_data, 32'h5555_AAAA);

`ifdef MEM_WB_LOAD_TIMEOUT_EN
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_rd = 5'd4; ex_funct3 = F3_LW; ex_result = 32'h0000_2000;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", {31'd0, stall}, 32'd1);
            chk("to_err_early", {31'd0, load_err}, 32'd0);
            tick();
        end
        chk("to_err", {31'd0, load_err}, 32'd1);
        chk("to_stall_drop", {31'd0, stall}, 32'd0);
        chk("to_we", {31'd0, wb_we}, 32'd0);
        tick();
        chk("to_err_once", {31'd0, load_err}, 32'd0);
`else
        // No watchdog: a slow response still completes normally
        apply(mk(1, 1, 5'd6, F3_LW, 32'h0000_2000, 32'h0BAD_F00D, 10, 32'h0BAD_F00D));
        chk("no_to_err", {31'd0, load_err}, 32'd0);
`endif

        // Reset while a load is pending, then a late response
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_rd = 5'd3; ex_funct3 = F3_LW; ex_result = 32'h0000_3000;
        tick();
        ex_valid = 1'b0;
        tick();
        chk("mid_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_we", {31'd0, wb_we}, 32'd0);
        chk("post_rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("post_rst_data", wb_data, 32'd0);
        chk("post_rst_err", {31'd0, load_err}, 32'd0);
        tick();

        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 255, the load-response watchdog limit in cycles (8-bit range, 1..255).
REQ-002 SHALL have clock and reset as decided: one clock; reset asynchronous, active-low. Ports are clk_i and rst_ni.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_i, input, 1: clock.
- rst_ni, input, 1: async active-low reset.
- ex_valid_i, input, 1: EX presents an instruction.
- ex_reg_write_i, input, 1: instruction writes rd.
- ex_mem_read_i, input, 1: instruction is a load.
- ex_rd_i, input, 5: destination register.
- ex_funct3_i, input, 3: load width/sign.
- ex_result_i, input, 32: ALU result, or the load address.
- dmem_rvalid_i, input, 1: data-memory response valid.
- dmem_rdata_i, input, 32: data-memory word.
- stall_o, output, 1: upstream hold.
- wb_reg_write_o, output, 1: RF write enable; also feeds the forwarding unit.
- wb_rd_o, output, 5: write register; also feeds the forwarding unit.
- wb_data_o, output, 32: write data.
- load_err_o, output, 1: load timeout pulse.

Function
REQ-004 SHALL implement a two-state FSM with states IDLE and WAIT.
REQ-005 SHALL accept EX inputs only in IDLE, and SHALL ignore them in WAIT.
REQ-006 SHALL handle a non-load (IDLE, ex_valid_i=1, ex_mem_read_i=0) with latency 1:
- wb_rd_o = ex_rd_i.
- wb_data_o = ex_result_i.
- wb_reg_write_o = ex_reg_write_i && (ex_rd_i != 0).
REQ-007 SHALL handle a load (IDLE, ex_valid_i=1, ex_mem_read_i=1) by capturing rd, funct3, reg_write and addr[1:0], then entering WAIT.
REQ-008 SHALL drive stall_o = (state == WAIT), combinationally, including the response cycle.
REQ-009 SHALL sample dmem_rvalid_i only in WAIT; the earliest legal response is the cycle after issue.
REQ-010 SHALL complete a load on dmem_rvalid_i in WAIT: next cycle it registers the aligned data, pulses wb_reg_write_o for 1 cycle (suppressed if rd == 0), and returns to IDLE.
REQ-011 SHALL align load data by funct3 and addr:
- 000 LB: byte at addr[1:0], sign-extended.
- 001 LH: half at addr[1], sign-extended.
- 010 LW: full word.
- 100 LBU: byte at addr[1:0], zero-extended.
- 101 LHU: half at addr[1], zero-extended.
- 011/110/111: treated as LW.
REQ-012 SHALL ignore addr[0] for halfwords; misalignment is not trapped.
REQ-013 SHALL pulse wb_reg_write_o for exactly 1 cycle per writing instruction.
REQ-014 SHALL hold wb_rd_o and wb_data_o at their last values when no write occurs.
REQ-015 SHALL ignore dmem_rvalid_i while in IDLE (stray or late responses).
REQ-016 SHALL never assert wb_reg_write_o with wb_rd_o == 0.

Reset
REQ-017 SHALL, while rst_ni = 0, force:
- state = IDLE.
- stall_o = 0.
- wb_reg_write_o = 0.
- wb_rd_o = 0.
- wb_data_o = 0.
- load_err_o = 0.
- watchdog counter = 0.
REQ-018 SHALL drop any pending load on reset mid-WAIT; a response arriving after reset is ignored (REQ-015).

Configuration
REQ-019 SHALL, with MEM_WB_LOAD_TIMEOUT_EN defined, run an 8-bit counter:
- Counter clears on entering WAIT and increments each WAIT cycle without dmem_rvalid_i.
- When it reaches LOAD_TIMEOUT, the block returns to IDLE, pulses load_err_o for 1 cycle, and keeps wb_reg_write_o = 0.
- dmem_rvalid_i in the same cycle as the limit wins as a normal completion.
REQ-020 SHALL, without MEM_WB_LOAD_TIMEOUT_EN, wait in WAIT indefinitely; load_err_o is tied 0 and the port is retained.

Structure
REQ-021 SHALL take the load funct3 encodings (LB, LH, LW, LBU, LHU) and the IDLE/WAIT state enum from shared package core_pkg.
REQ-022 SHALL place the data extraction in combinational sub-module load_align (inputs funct3, addr[1:0], rdata; output 32-bit data).

Verification
REQ-023 Non-load: IDLE, ALU op with rd=5, result 0x0000_1234 -> next cycle wb_reg_write_o=1, wb_rd_o=5, wb_data_o=0x0000_1234, stall_o=0.
REQ-024 LB: load with addr[1:0]=3, rd=7, funct3=000; rdata 0x80FF_0011 arrives 3 cycles later -> stall_o=1 for 3 cycles; then wb_data_o=0xFFFF_FF80 and wb_reg_write_o=1 for one cycle.
REQ-025 LHU: load with addr[1:0]=2, rdata 0xBEEF_1234 -> wb_data_o=0x0000_BEEF.
REQ-026 x0 guard: ALU op with rd=0, ex_reg_write_i=1 -> wb_reg_write_o stays 0; wb_data_o is updated.
REQ-027 Reset mid-WAIT: rst_ni low for 1 cycle during WAIT, then dmem_rvalid_i=1 -> all outputs 0 and no write.
REQ-028 Timeout (macro on, LOAD_TIMEOUT=4): no response -> load_err_o pulses once, 4 cycles after WAIT entry; stall_o drops; wb_reg_write_o=0.
